result_lifo_stack: RTL and testbench

- Parametrised last-in-first-out buffer for ALU results tagged with their opcode.
- Sits between the ALU and the LED/7-segment display path in the calculator top level.
- Next generation of the fixed 6-bit/3-bit result stack: width, depth and overflow policy are configurable.
- Adds optional edge detection of the push/pop button strobes, simultaneous push/pop, occupancy count and sticky error flags.

---
 rtl/result_lifo_stack_if.sv | 32 +++
 rtl/result_lifo_stack.sv | 143 ++++++++++++++
 tb/tb_result_lifo_stack.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/result_lifo_stack_if.sv
// rtl/result_lifo_stack_if.sv - push/pop request and result bus of the result LIFO stack
interface result_lifo_stack_if #(
    parameter int DATA_W = 6,
    parameter int OP_W   = 3,
    parameter int DEPTH  = 8
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic              push;
    logic              pop;
    logic              clear_err;
    logic [DATA_W-1:0] din_result;
    logic [OP_W-1:0]   din_opcode;
    logic [DATA_W-1:0] dout_result;
    logic [OP_W-1:0]   dout_opcode;
    logic              dout_valid;
    logic [CNT_W-1:0]  count;
    logic              full;
    logic              empty;
    logic              overflow;
    logic              underflow;

    modport master (
        output push, pop, clear_err, din_result, din_opcode,
        input  dout_result, dout_opcode, dout_valid, count, full, empty, overflow, underflow
    );

    modport slave (
        input  push, pop, clear_err, din_result, din_opcode,
        output dout_result, dout_opcode, dout_valid, count, full, empty, overflow, underflow
    );
endinterface

// File: rtl/result_lifo_stack.sv
// rtl/result_lifo_stack.sv - LIFO of opcode-tagged ALU results with optional overwrite of oldest
module result_lifo_stack #(
    parameter int DATA_W      = 6,
    parameter int OP_W        = 3,
    parameter int DEPTH       = 8,
    parameter int OVERWRITE   = 0,
    parameter int EDGE_DETECT = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    result_lifo_stack_if.slave   bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int ENT_W = DATA_W + OP_W;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [PTR_W-1:0] ptr_dec(input logic [PTR_W-1:0] p);
        return (p == '0) ? LAST_PTR : p - 1'b1;
    endfunction

    logic [ENT_W-1:0]  mem [DEPTH];
    // top_ptr is the next free slot; base_ptr is the oldest entry and only
    // moves when a full stack overwrites its bottom.
    logic [PTR_W-1:0]  base_ptr, top_ptr;
    logic [CNT_W-1:0]  count_r;
    logic              push_q, pop_q;
    logic [DATA_W-1:0] dout_result_r;
    logic [OP_W-1:0]   dout_opcode_r;
    logic              dout_valid_r;
    logic              overflow_r, underflow_r;

    logic              push_req, pop_req;
    logic              is_full, is_empty;
    logic [PTR_W-1:0]  top_idx;
    logic [ENT_W-1:0]  entry_in;

    logic              mem_we;
    logic [PTR_W-1:0]  mem_waddr;
    logic [PTR_W-1:0]  top_nxt, base_nxt;
    logic [CNT_W-1:0]  count_nxt;
    logic              out_load;
    logic [ENT_W-1:0]  out_data;
    logic              ovf_evt, udf_evt;

    assign push_req = (EDGE_DETECT != 0) ? (bus.push & ~push_q) : bus.push;
    assign pop_req  = (EDGE_DETECT != 0) ? (bus.pop  & ~pop_q)  : bus.pop;
    assign is_full  = (count_r == FULL_CNT);
    assign is_empty = (count_r == '0);
    assign top_idx  = ptr_dec(top_ptr);
    assign entry_in = {bus.din_opcode, bus.din_result};

    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = top_ptr;
        top_nxt   = top_ptr;
        base_nxt  = base_ptr;
        count_nxt = count_r;
        out_load  = 1'b0;
        out_data  = mem[top_idx];
        ovf_evt   = 1'b0;
        udf_evt   = 1'b0;
        if (push_req && pop_req) begin
            out_load = 1'b1;
            if (is_empty) begin
                out_data = entry_in;
            end else begin
                mem_we    = 1'b1;
                mem_waddr = top_idx;
            end
        end else if (push_req) begin
            if (!is_full) begin
                mem_we    = 1'b1;
                top_nxt   = ptr_inc(top_ptr);
                count_nxt = count_r + 1'b1;
            end else begin
                ovf_evt = 1'b1;
                // When full, top_ptr equals base_ptr: writing there evicts the oldest.
                if (OVERWRITE != 0) begin
                    mem_we   = 1'b1;
                    top_nxt  = ptr_inc(top_ptr);
                    base_nxt = ptr_inc(base_ptr);
                end
            end
        end else if (pop_req) begin
            if (!is_empty) begin
                out_load  = 1'b1;
                top_nxt   = top_idx;
                count_nxt = count_r - 1'b1;
            end else begin
                udf_evt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we && !reset) begin
            mem[mem_waddr] <= entry_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            base_ptr      <= '0;
            top_ptr       <= '0;
            count_r       <= '0;
            push_q        <= 1'b1;
            pop_q         <= 1'b1;
            dout_result_r <= '0;
            dout_opcode_r <= '0;
            dout_valid_r  <= 1'b0;
            overflow_r    <= 1'b0;
            underflow_r   <= 1'b0;
        end else begin
            base_ptr     <= base_nxt;
            top_ptr      <= top_nxt;
            count_r      <= count_nxt;
            push_q       <= bus.push;
            pop_q        <= bus.pop;
            dout_valid_r <= out_load;
            if (out_load) begin
                dout_result_r <= out_data[DATA_W-1:0];
                dout_opcode_r <= out_data[ENT_W-1:DATA_W];
            end
            overflow_r  <= ovf_evt | (overflow_r  & ~bus.clear_err);
            underflow_r <= udf_evt | (underflow_r & ~bus.clear_err);
        end
    end

    assign bus.dout_result = dout_result_r;
    assign bus.dout_opcode = dout_opcode_r;
    assign bus.dout_valid  = dout_valid_r;
    assign bus.count       = count_r;
    assign bus.full        = is_full;
    assign bus.empty       = is_empty;
    assign bus.overflow    = overflow_r;
    assign bus.underflow   = underflow_r;
endmodule

// File: tb/tb_result_lifo_stack.sv
// tb/tb_result_lifo_stack.sv - directed self-checking bench, DEPTH=4, drop and overwrite variants
module tb_result_lifo_stack;
    logic       clk = 1'b0;
    logic       reset;
    logic       push, pop, clear_err;
    logic [5:0] din_result;
    logic [2:0] din_opcode;
    int         n_cmp = 0;
    int         n_err = 0;

    always #5 clk = ~clk;

    result_lifo_stack_if #(.DATA_W(6), .OP_W(3), .DEPTH(4)) ifa ();
    result_lifo_stack_if #(.DATA_W(6), .OP_W(3), .DEPTH(4)) ifb ();

    assign ifa.push = push;       assign ifb.push = push;
    assign ifa.pop = pop;         assign ifb.pop = pop;
    assign ifa.clear_err = clear_err;   assign ifb.clear_err = clear_err;
    assign ifa.din_result = din_result; assign ifb.din_result = din_result;
    assign ifa.din_opcode = din_opcode; assign ifb.din_opcode = din_opcode;

    result_lifo_stack #(.DATA_W(6), .OP_W(3), .DEPTH(4), .OVERWRITE(0), .EDGE_DETECT(1)) dut_a (
        .clk(clk), .reset(reset), .bus(ifa));
    result_lifo_stack #(.DATA_W(6), .OP_W(3), .DEPTH(4), .OVERWRITE(1), .EDGE_DETECT(1)) dut_b (
        .clk(clk), .reset(reset), .bus(ifb));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();
    endtask

    task automatic push_one(input logic [5:0] d, input logic [2:0] o);
        din_result = d;
        din_opcode = o;
        push = 1'b1;
        step();
        push = 1'b0;
        step();
    endtask

    task automatic pop_both(input string tag, input logic [5:0] ar, input logic [2:0] ao,
                            input logic [5:0] br, input logic [2:0] bo);
        pop = 1'b1;
        step();
        check({tag, " a_valid"}, ifa.dout_valid, 1);
        check({tag, " a_result"}, ifa.dout_result, ar);
        check({tag, " a_opcode"}, ifa.dout_opcode, ao);
        check({tag, " b_valid"}, ifb.dout_valid, 1);
        check({tag, " b_result"}, ifb.dout_result, br);
        check({tag, " b_opcode"}, ifb.dout_opcode, bo);
        pop = 1'b0;
        step();
        check({tag, " a_valid_drop"}, ifa.dout_valid, 0);
    endtask

    initial begin
        reset = 1'b0; push = 1'b0; pop = 1'b0; clear_err = 1'b0;
        din_result = '0; din_opcode = '0;
        do_reset();
        check("rst count", ifa.count, 0);
        check("rst empty", ifa.empty, 1);
        check("rst full", ifa.full, 0);
        check("rst dout", {ifa.dout_opcode, ifa.dout_result}, 0);
        check("rst valid", ifa.dout_valid, 0);
        check("rst flags", {ifa.overflow, ifa.underflow}, 0);

        // basic LIFO order
        push_one(6'h05, 3'd1);
        push_one(6'h0A, 3'd2);
        push_one(6'h1F, 3'd3);
        check("t1 count3", ifa.count, 3);
        pop_both("t1 pop1", 6'h1F, 3'd3, 6'h1F, 3'd3);
        check("t1 count2", ifa.count, 2);
        pop_both("t1 pop2", 6'h0A, 3'd2, 6'h0A, 3'd2);
        pop_both("t1 pop3", 6'h05, 3'd1, 6'h05, 3'd1);
        check("t1 count0", ifa.count, 0);
        check("t1 empty", ifa.empty, 1);

        // fill past capacity: a drops, b overwrites oldest
        do_reset();
        for (int i = 1; i <= 6; i++) begin
            push_one(6'(i), 3'(i));
            if (i == 3) check("t2 not_full3", ifa.full, 0);
            if (i == 4) begin
                check("t2 a_full4", ifa.full, 1);
                check("t2 a_ovf4", ifa.overflow, 0);
                check("t2 b_ovf4", ifb.overflow, 0);
            end
            if (i == 5) begin
                check("t2 a_ovf5", ifa.overflow, 1);
                check("t2 b_ovf5", ifb.overflow, 1);
            end
        end
        check("t2 a_count", ifa.count, 4);
        check("t2 b_count", ifb.count, 4);
        pop_both("t2 pop1", 6'd4, 3'd4, 6'd6, 3'd6);
        pop_both("t2 pop2", 6'd3, 3'd3, 6'd5, 3'd5);
        pop_both("t2 pop3", 6'd2, 3'd2, 6'd4, 3'd4);
        pop_both("t2 pop4", 6'd1, 3'd1, 6'd3, 3'd3);
        check("t2 a_empty", ifa.empty, 1);
        check("t2 b_empty", ifb.empty, 1);
        check("t2 ovf_sticky", ifa.overflow, 1);

        // underflow, pass-through, clear_err
        do_reset();
        pop = 1'b1;
        step();
        check("t3 udf", ifa.underflow, 1);
        check("t3 udf_valid", ifa.dout_valid, 0);
        check("t3 udf_dout", ifa.dout_result, 0);
        pop = 1'b0;
        step();
        din_result = 6'h2A; din_opcode = 3'd5;
        push = 1'b1; pop = 1'b1;
        step();
        check("t3 pt_valid", ifa.dout_valid, 1);
        check("t3 pt_result", ifa.dout_result, 6'h2A);
        check("t3 pt_opcode", ifa.dout_opcode, 3'd5);
        check("t3 pt_count", ifa.count, 0);
        check("t3 pt_udf_kept", ifa.underflow, 1);
        push = 1'b0; pop = 1'b0;
        step();
        clear_err = 1'b1;
        step();
        clear_err = 1'b0;
        check("t3 clr", ifa.underflow, 0);
        clear_err = 1'b1; pop = 1'b1;
        step();
        check("t3 clr_vs_err", ifa.underflow, 1);
        clear_err = 1'b0; pop = 1'b0;
        step();

        // swap top on a non-empty stack
        do_reset();
        push_one(6'h11, 3'd1);
        push_one(6'h22, 3'd2);
        din_result = 6'h33; din_opcode = 3'd3;
        push = 1'b1; pop = 1'b1;
        step();
        check("t4 swap_result", ifa.dout_result, 6'h22);
        check("t4 swap_valid", ifa.dout_valid, 1);
        check("t4 swap_count", ifa.count, 2);
        push = 1'b0; pop = 1'b0;
        step();
        pop_both("t4 pop1", 6'h33, 3'd3, 6'h33, 3'd3);
        pop_both("t4 pop2", 6'h11, 3'd1, 6'h11, 3'd1);

        // edge detection: held strobe is one request; strobe held across reset is none
        do_reset();
        din_result = 6'h07; din_opcode = 3'd7;
        push = 1'b1;
        repeat (10) step();
        check("t5 held_count", ifa.count, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        repeat (3) step();
        check("t5 rst_held_count", ifa.count, 0);
        push = 1'b0;
        step();

        // reset during a pop
        push_one(6'h01, 3'd1);
        push_one(6'h02, 3'd2);
        push_one(6'h03, 3'd3);
        check("t6 count3", ifa.count, 3);
        reset = 1'b1; pop = 1'b1;
        step();
        check("t6 rst_count", ifa.count, 0);
        check("t6 rst_valid", ifa.dout_valid, 0);
        check("t6 rst_dout", ifa.dout_result, 0);
        reset = 1'b0; pop = 1'b0;
        step();
        pop = 1'b1;
        step();
        check("t6 udf", ifa.underflow, 1);
        check("t6 udf_valid", ifa.dout_valid, 0);
        pop = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
